pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 92 +++++++++
 rtl/pipe_sat_counter.sv | 31 +++
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the pipeline-stage register and the per-stage payload structs.
// Stage wrappers cast these structs to the flat data/control vectors of pipe_stage_reg.
package pipe_stage_reg_pkg;

  localparam int XLEN          = 32;
  localparam int STAT_W        = 32;
  localparam int DEF_DATA_W    = 128;
  localparam int DEF_CTRL_W    = 8;

  // Which update the register performs on the coming edge, in priority order.
  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_FLUSH = 2'd1,
    OP_HOLD  = 2'd2,
    OP_LOAD  = 2'd3
  } stage_op_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pred_target;
  } pipeline_data_t_ifid;

  typedef struct packed {
    logic predicted_taken;
    logic [6:0] spare;
  } pipeline_control_t_ifid;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
  } pipeline_data_t_idex;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic jump;
    logic alu_src;
    logic pc_to_reg;
  } pipeline_control_t_idex;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_val;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd_idx;
  } pipeline_data_t_exmem;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic pc_to_reg;
    logic [2:0] mem_size;
  } pipeline_control_t_exmem;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd_idx;
  } pipeline_data_t_memwb;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic pc_to_reg;
    logic [4:0] spare;
  } pipeline_control_t_memwb;

  // Bubble constants: every write, memory and branch enable is off.
  localparam pipeline_control_t_ifid  CTRL_BUBBLE_IFID  = '0;
  localparam pipeline_control_t_idex  CTRL_BUBBLE_IDEX  = '0;
  localparam pipeline_control_t_exmem CTRL_BUBBLE_EXMEM = '0;
  localparam pipeline_control_t_memwb CTRL_BUBBLE_MEMWB = '0;

  function automatic stage_op_t decode_op(input logic reset, input logic flush,
                                          input logic stall);
    if (reset)      return OP_RESET;
    else if (flush) return OP_FLUSH;
    else if (stall) return OP_HOLD;
    else            return OP_LOAD;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register with valid tracking, stall (hold) and flush (bubble).
// Optional stall/bubble statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 CTRL_W      = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic              stall,
  input  logic              flush,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_count,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] control_out
);

  stage_op_t         op;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  assign op = decode_op(reset, flush, stall);

  // Flush keeps the old payload; a bubble load still captures data_in so the
  // data path needs no enable, only control is forced to the bubble value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    unique case (op)
      OP_RESET: begin
        valid_d = 1'b0;
        data_d  = '0;
        ctrl_d  = CTRL_BUBBLE;
      end
      OP_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_BUBBLE;
      end
      OP_HOLD: begin
        valid_d = valid_q;
      end
      OP_LOAD: begin
        valid_d = in_valid;
        data_d  = data_in;
        ctrl_d  = in_valid ? control_in : CTRL_BUBBLE;
      end
      default: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_BUBBLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid   = valid_q;
  assign data_out    = data_q;
  assign control_out = ctrl_q;

`ifdef PIPE_STAGE_STATS_EN
  logic stall_inc;
  logic bubble_inc;

  // A bubble is counted on every edge that writes out_valid=0 (flush or empty load).
  assign stall_inc  = (op == OP_HOLD);
  assign bubble_inc = (op == OP_FLUSH) || ((op == OP_LOAD) && !in_valid);

  pipe_sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
    .clk_i   (clock),
    .clear_i (reset),
    .inc_i   (stall_inc),
    .count_o (stall_cycles)
  );

  pipe_sat_counter #(.WIDTH(STAT_W)) u_bubble_cnt (
    .clk_i   (clock),
    .clear_i (reset),
    .inc_i   (bubble_inc),
    .count_o (bubble_count)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg plus a narrow pipe_sat_counter for saturation.
module tb_pipe_stage_reg;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 8;
  localparam logic [CTRL_W-1:0] BUB = 8'h00;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic [CTRL_W-1:0] control_in;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] data_out;
  logic [CTRL_W-1:0] control_out;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       bubble_count;
`endif

  logic       sat_clear;
  logic       sat_inc;
  logic [3:0] sat_count;

  int vec_count = 0;
  int err_count = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (BUB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .control_in  (control_in),
    .stall       (stall),
    .flush       (flush),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cycles(stall_cycles),
    .bubble_count(bubble_count),
`endif
    .out_valid   (out_valid),
    .data_out    (data_out),
    .control_out (control_out)
  );

  pipe_sat_counter #(.WIDTH(4)) u_sat (
    .clk_i   (clock),
    .clear_i (sat_clear),
    .inc_i   (sat_inc),
    .count_o (sat_count)
  );

  // Advance one rising edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; data_in = 128'd1234; control_in = 8'h5A;
    stall = 1'b0; flush = 1'b0;
    step();
    step();
    vec_count++;
    if (out_valid !== 1'b0) begin err_count++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    vec_count++;
    if (control_out !== BUB) begin err_count++; $display("FAIL reset_ctrl got %h want %h", control_out, BUB); end
    vec_count++;
    if (data_out !== 128'd0) begin err_count++; $display("FAIL reset_data got %0d want 0", data_out); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    in_valid = 1'b1; data_in = 128'd123456; control_in = 8'hA5;
    step();
    vec_count++;
    if (out_valid !== 1'b1) begin err_count++; $display("FAIL load_valid got %0b want 1", out_valid); end
    vec_count++;
    if (data_out !== 128'd123456) begin err_count++; $display("FAIL load_data got %0d want 123456", data_out); end
    vec_count++;
    if (control_out !== 8'hA5) begin err_count++; $display("FAIL load_ctrl got %h want a5", control_out); end
  endtask

  task automatic test_stall();
    stall = 1'b1; data_in = 128'd4321; control_in = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_count++;
      if (out_valid !== 1'b1 || data_out !== 128'd123456 || control_out !== 8'hA5) begin
        err_count++;
        $display("FAIL stall_hold[%0d] got v=%0b d=%0d c=%h want v=1 d=123456 c=a5",
                 i, out_valid, data_out, control_out);
      end
    end
    stall = 1'b0;
    step();
    vec_count++;
    if (out_valid !== 1'b1 || data_out !== 128'd4321 || control_out !== 8'h3C) begin
      err_count++;
      $display("FAIL stall_release got v=%0b d=%0d c=%h want v=1 d=4321 c=3c",
               out_valid, data_out, control_out);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; data_in = 128'd123456; control_in = 8'hA5;
    step();
    flush = 1'b1; stall = 1'b1; data_in = 128'd999; control_in = 8'h77;
    step();
    flush = 1'b0; stall = 1'b0;
    vec_count++;
    if (out_valid !== 1'b0) begin err_count++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    vec_count++;
    if (control_out !== BUB) begin err_count++; $display("FAIL flush_ctrl got %h want %h", control_out, BUB); end
    vec_count++;
    if (data_out !== 128'd123456) begin err_count++; $display("FAIL flush_data got %0d want 123456", data_out); end
  endtask

  task automatic test_bubble_load();
    in_valid = 1'b0; data_in = 128'd77; control_in = 8'hFF;
    step();
    vec_count++;
    if (out_valid !== 1'b0 || control_out !== BUB || data_out !== 128'd77) begin
      err_count++;
      $display("FAIL bubble_load got v=%0b d=%0d c=%h want v=0 d=77 c=%h",
               out_valid, data_out, control_out, BUB);
    end
    // A stalled bubble must stay a bubble even with a real instruction waiting.
    stall = 1'b1; in_valid = 1'b1; data_in = 128'd55; control_in = 8'hC3;
    step();
    step();
    vec_count++;
    if (out_valid !== 1'b0 || control_out !== BUB || data_out !== 128'd77) begin
      err_count++;
      $display("FAIL bubble_stall got v=%0b d=%0d c=%h want v=0 d=77 c=%h",
               out_valid, data_out, control_out, BUB);
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; data_in = 128'd11; control_in = 8'hA5;
    step();
    stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    vec_count++;
    if (out_valid !== 1'b0 || control_out !== BUB || data_out !== 128'd0) begin
      err_count++;
      $display("FAIL reset_mid_stall got v=%0b d=%0d c=%h want v=0 d=0 c=%h",
               out_valid, data_out, control_out, BUB);
    end
    reset = 1'b0; stall = 1'b0; data_in = 128'd22; control_in = 8'h81;
    step();
    vec_count++;
    if (out_valid !== 1'b1 || control_out !== 8'h81 || data_out !== 128'd22) begin
      err_count++;
      $display("FAIL post_reset_load got v=%0b d=%0d c=%h want v=1 d=22 c=81",
               out_valid, data_out, control_out);
    end
  endtask

  task automatic test_back_to_back();
    logic              v_tab [6];
    logic [CTRL_W-1:0] c_tab [6];
    logic [CTRL_W-1:0] exp_c;
    v_tab = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    c_tab = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      in_valid = v_tab[i]; control_in = c_tab[i]; data_in = 128'(1000 + i);
      step();
      exp_c = v_tab[i] ? c_tab[i] : BUB;
      vec_count++;
      if (out_valid !== v_tab[i] || control_out !== exp_c || data_out !== 128'(1000 + i)) begin
        err_count++;
        $display("FAIL b2b[%0d] got v=%0b d=%0d c=%h want v=%0b d=%0d c=%h",
                 i, out_valid, data_out, control_out, v_tab[i], 1000 + i, exp_c);
      end
    end
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    step();
    reset = 1'b0;
    vec_count++;
    if (stall_cycles !== 32'd0 || bubble_count !== 32'd0) begin
      err_count++;
      $display("FAIL stats_reset got s=%0d b=%0d want 0/0", stall_cycles, bubble_count);
    end
    in_valid = 1'b1; data_in = 128'd5; control_in = 8'h0F;
    step();
    stall = 1'b1;
    repeat (5) step();
    stall = 1'b0; flush = 1'b1;
    repeat (2) step();
    flush = 1'b0;
    vec_count++;
    if (stall_cycles !== 32'd5) begin err_count++; $display("FAIL stats_stall got %0d want 5", stall_cycles); end
    vec_count++;
    if (bubble_count !== 32'd2) begin err_count++; $display("FAIL stats_bubble got %0d want 2", bubble_count); end
  endtask
`endif

  task automatic test_saturation();
    sat_clear = 1'b1; sat_inc = 1'b0;
    step();
    sat_clear = 1'b0; sat_inc = 1'b1;
    repeat (14) step();
    vec_count++;
    if (sat_count !== 4'd14) begin err_count++; $display("FAIL sat_near_max got %0d want 14", sat_count); end
    repeat (6) step();
    vec_count++;
    if (sat_count !== 4'hF) begin err_count++; $display("FAIL sat_stick got %h want f", sat_count); end
    sat_inc = 1'b0;
  endtask

  initial begin
    sat_clear = 1'b1; sat_inc = 1'b0;
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_bubble_load();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
